// File: rtl/nibble_serial_adder.sv
// rtl/nibble_serial_adder.sv - bit-serial-by-nibble ripple-carry adder with IDLE/RUN/DONE control

module nibble_serial_adder #(
  parameter int WORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [4*WORDS-1:0]   A,
  input  logic [4*WORDS-1:0]   B,
  input  logic                 Cin,
  output logic                 busy,
  output logic                 done,
  output logic [4*WORDS-1:0]   S,
  output logic                 Cout,
  output logic                 ovf
);

  localparam int W = 4 * WORDS;
  localparam logic [3:0] LAST = 4'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state_q, state_d;
  logic [3:0]     cnt_q, cnt_d;
  logic           carry_q, carry_d;
  logic [W-1:0]   a_q, a_d;
  logic [W-1:0]   b_q, b_d;
  logic [W-1:0]   acc_q, acc_d;
  logic [W-1:0]   s_q, s_d;
  logic           cout_q, cout_d;
  logic           ovf_q, ovf_d;

  logic [4:0]     c;
  logic [3:0]     sum;
  logic [W+3:0]   shifted;

  // One shared 4-bit ripple-carry slice working on the low nibble of the operand shifters
  always_comb begin
    c    = '0;
    sum  = '0;
    c[0] = carry_q;
    for (int i = 0; i < 4; i++) begin
      sum[i]   = a_q[i] ^ b_q[i] ^ c[i];
      c[i+1]   = (a_q[i] & b_q[i]) | (a_q[i] & c[i]) | (b_q[i] & c[i]);
    end
  end

  // Next-state, datapath updates and status outputs
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    s_d     = s_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    // New slice result enters from the MSB end; the accumulator is internal so
    // the visible S keeps the previous result until the final nibble lands.
    shifted = {sum, acc_q};
    busy    = (state_q != IDLE);
    done    = (state_q == DONE);

    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = Cin;
          cnt_d   = LAST;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = shifted[W+3:4];
        carry_d = c[4];
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        if (cnt_q == 4'd0) begin
          s_d     = shifted[W+3:4];
          cout_d  = c[4];
          ovf_d   = c[3] ^ c[4];
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers, cleared asynchronously by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign S    = s_q;
  assign Cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// tb/tb_nibble_serial_adder.sv - randomized self-checking bench for nibble_serial_adder

module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic        start4 = 1'b0;
  logic [15:0] a4 = '0, b4 = '0;
  logic        cin4 = 1'b0;
  logic        busy4, done4, cout4, ovf4;
  logic [15:0] s4;

  logic        start1 = 1'b0;
  logic [3:0]  a1 = '0, b1 = '0;
  logic        cin1 = 1'b0;
  logic        busy1, done1, cout1, ovf1;
  logic [3:0]  s1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  nibble_serial_adder #(.WORDS(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .busy(busy4), .done(done4), .S(s4), .Cout(cout4), .ovf(ovf4)
  );

  nibble_serial_adder #(.WORDS(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .A(a1), .B(b1), .Cin(cin1),
    .busy(busy1), .done(done1), .S(s1), .Cout(cout1), .ovf(ovf1)
  );

  // Reference: {ovf, Cout, S} from plain integer addition and sign rules
  function automatic logic [17:0] model4(input logic [15:0] a, input logic [15:0] b, input logic cin);
    logic [16:0] full;
    logic        ov;
    full = {1'b0, a} + {1'b0, b} + {16'd0, cin};
    ov   = (a[15] == b[15]) && (full[15] != a[15]);
    return {ov, full};
  endfunction

  function automatic logic [5:0] model1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    logic [4:0] full;
    logic       ov;
    full = {1'b0, a} + {1'b0, b} + {4'd0, cin};
    ov   = (a[3] == b[3]) && (full[3] != a[3]);
    return {ov, full};
  endfunction

  task automatic accept4(input logic [15:0] a, input logic [15:0] b, input logic cin);
    int g;
    g = 0;
    while (busy4 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    a4 = a; b4 = b; cin4 = cin; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
  endtask

  task automatic accept1(input logic [3:0] a, input logic [3:0] b, input logic cin);
    int g;
    g = 0;
    while (busy1 && g < 50) begin
      @(posedge clk); #1; g++;
    end
    a1 = a; b1 = b; cin1 = cin; start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
  endtask

  task automatic wait_done4(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done4 && n < 40);
  endtask

  task automatic wait_done1(output int n);
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!done1 && n < 40);
  endtask

  task automatic test_reset;
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, s4, cout4, ovf4} !== 20'd0) begin
      errors++; $display("FAIL reset_outputs4 got=%h exp=0", {busy4, done4, s4, cout4, ovf4});
    end
    checks++;
    if ({busy1, done1, s1, cout1, ovf1} !== 8'd0) begin
      errors++; $display("FAIL reset_outputs1 got=%h exp=0", {busy1, done1, s1, cout1, ovf1});
    end
    a4 = 16'h0005; b4 = 16'h0005; start4 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy4 !== 1'b0) begin
      errors++; $display("FAIL start_in_reset busy got=%b exp=0", busy4);
    end
    start4 = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (busy4 !== 1'b0) begin
      errors++; $display("FAIL after_release busy got=%b exp=0", busy4);
    end
  endtask

  task automatic test_carry_wrap;
    logic [17:0] e;
    e = model4(16'hFFFF, 16'h0001, 1'b0);
    accept4(16'hFFFF, 16'h0001, 1'b0);
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk); #1;
      checks++;
      if (busy4 !== (k <= 4)) begin
        errors++; $display("FAIL wrap_busy edge=%0d got=%b exp=%b", k, busy4, (k <= 4));
      end
      checks++;
      if (done4 !== (k == 4)) begin
        errors++; $display("FAIL wrap_done edge=%0d got=%b exp=%b", k, done4, (k == 4));
      end
      if (k < 4) begin
        checks++;
        if ({cout4, ovf4} !== 2'b00) begin
          errors++; $display("FAIL wrap_hold edge=%0d got=%b exp=00", k, {cout4, ovf4});
        end
      end
      if (k == 4) begin
        checks++;
        if (s4 !== 16'h0000 || cout4 !== 1'b1 || ovf4 !== 1'b0 || {ovf4, cout4, s4} !== e) begin
          errors++; $display("FAIL wrap_result got S=%h C=%b V=%b exp S=0000 C=1 V=0", s4, cout4, ovf4);
        end
      end
    end
  endtask

  task automatic test_overflow;
    int n;
    accept4(16'h7FFF, 16'h0001, 1'b0);
    wait_done4(n);
    checks++;
    if ({ovf4, cout4, s4} !== {1'b1, 1'b0, 16'h8000}) begin
      errors++; $display("FAIL ovf_pos got S=%h C=%b V=%b exp S=8000 C=0 V=1", s4, cout4, ovf4);
    end
    accept4(16'h8000, 16'h8000, 1'b0);
    wait_done4(n);
    checks++;
    if ({ovf4, cout4, s4} !== {1'b1, 1'b1, 16'h0000}) begin
      errors++; $display("FAIL ovf_neg got S=%h C=%b V=%b exp S=0000 C=1 V=1", s4, cout4, ovf4);
    end
  endtask

  task automatic test_operand_hold;
    int n;
    accept4(16'h1234, 16'h4321, 1'b1);
    n = 0;
    do begin
      a4 = 16'($urandom); b4 = 16'($urandom); cin4 = 1'($urandom);
      @(posedge clk); #1; n++;
    end while (!done4 && n < 40);
    checks++;
    if (n !== 4) begin
      errors++; $display("FAIL hold_latency got=%0d exp=4", n);
    end
    checks++;
    if ({ovf4, cout4, s4} !== {1'b0, 1'b0, 16'h5556}) begin
      errors++; $display("FAIL hold_result got S=%h C=%b V=%b exp S=5556 C=0 V=0", s4, cout4, ovf4);
    end
  endtask

  task automatic test_start_ignored;
    int pulses;
    int n;
    pulses = 0;
    accept4(16'h0101, 16'h0202, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #1;
      if (done4) pulses++;
      if (k == 4) begin
        checks++;
        if (s4 !== 16'h0303) begin
          errors++; $display("FAIL ignore_result got=%h exp=0303", s4);
        end
      end
      if (k == 6) begin
        checks++;
        if (busy4 !== 1'b0) begin
          errors++; $display("FAIL ignore_busy got=%b exp=0", busy4);
        end
      end
      start4 = (k == 1) || (k == 4);
    end
    checks++;
    if (pulses !== 1) begin
      errors++; $display("FAIL ignore_pulses got=%0d exp=1", pulses);
    end
    accept4(16'h00FF, 16'h0001, 1'b0);
    wait_done4(n);
    checks++;
    if (n !== 4 || s4 !== 16'h0100) begin
      errors++; $display("FAIL ignore_next got n=%0d S=%h exp n=4 S=0100", n, s4);
    end
  endtask

  task automatic test_reset_mid_run;
    int pulses;
    int n;
    pulses = 0;
    accept4(16'h1111, 16'h2222, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy4, done4, s4, cout4, ovf4} !== 20'd0) begin
      errors++; $display("FAIL midrun_async got=%h exp=0", {busy4, done4, s4, cout4, ovf4});
    end
    repeat (3) begin
      @(posedge clk); #1;
      if (done4) pulses++;
    end
    @(negedge clk) rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done4) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL midrun_no_done got=%0d exp=0", pulses);
    end
    accept4(16'h0003, 16'h0004, 1'b0);
    wait_done4(n);
    checks++;
    if (n !== 4 || {ovf4, cout4, s4} !== {1'b0, 1'b0, 16'h0007}) begin
      errors++; $display("FAIL midrun_restart got n=%0d S=%h exp n=4 S=0007", n, s4);
    end
  endtask

  task automatic test_random4;
    logic [15:0] a, b;
    logic        ci;
    logic [17:0] e;
    int          n;
    for (int v = 0; v < 200; v++) begin
      a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
      if (v == 0) begin a = 16'hFFFF; b = 16'hFFFF; ci = 1'b1; end
      e = model4(a, b, ci);
      accept4(a, b, ci);
      wait_done4(n);
      checks++;
      if (n !== 4 || {ovf4, cout4, s4} !== e) begin
        errors++;
        $display("FAIL rand4 A=%h B=%h Cin=%b got n=%0d V/C/S=%h exp n=4 V/C/S=%h", a, b, ci, n, {ovf4, cout4, s4}, e);
      end
    end
  endtask

  task automatic test_words1;
    logic [3:0] a, b;
    logic       ci;
    logic [5:0] e;
    int         n;
    accept1(4'hF, 4'h1, 1'b1);
    wait_done1(n);
    checks++;
    if (n !== 1 || {ovf1, cout1, s1} !== {1'b0, 1'b1, 4'h1}) begin
      errors++; $display("FAIL w1_basic got n=%0d S=%h C=%b V=%b exp n=1 S=1 C=1 V=0", n, s1, cout1, ovf1);
    end
    for (int v = 0; v < 10000; v++) begin
      a = 4'($urandom); b = 4'($urandom); ci = 1'($urandom);
      e = model1(a, b, ci);
      accept1(a, b, ci);
      wait_done1(n);
      checks++;
      if (n !== 1 || {ovf1, cout1, s1} !== e) begin
        errors++;
        $display("FAIL rand1 A=%h B=%h Cin=%b got n=%0d V/C/S=%h exp n=1 V/C/S=%h", a, b, ci, n, {ovf1, cout1, s1}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_carry_wrap();
    test_overflow();
    test_operand_hold();
    test_start_ignored();
    test_reset_mid_run();
    test_random4();
    test_words1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

Interface
REQ-001 Parameter WORDS SHALL default to 4 and set the number of 4-bit nibbles per operand; legal range is 1..16; operand width is W = 4*WORDS.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a new addition; sampled only in IDLE.
REQ-005 A  input  W  first operand; sampled on the accepting edge.
REQ-006 B  input  W  second operand; sampled on the accepting edge.
REQ-007 Cin  input  1  carry into nibble 0; sampled on the accepting edge.
REQ-008 busy  output  1  high from the accepting edge until the return to IDLE.
REQ-009 done  output  1  single-cycle pulse marking valid results.
REQ-010 S  output  W  sum, registered.
REQ-011 Cout  output  1  carry out of the MSB nibble, registered.
REQ-012 ovf  output  1  two's-complement overflow, registered.

Function
REQ-013 The block SHALL compute {Cout,S} = A + B + Cin using one 4-bit ripple-carry slice (3-input majority carry, XOR sum per bit), reused once per nibble, LSB nibble first.
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 IDLE -> RUN on an edge with start=1: A, B and Cin are captured into internal shift and carry registers; the nibble counter loads WORDS-1; busy rises.
REQ-016 In RUN, each edge SHALL add the current low nibbles of the captured A and B plus the carry register, shift the 4-bit result into S from the MSB end, store the slice carry, and shift both operand registers right by 4.
REQ-017 RUN -> DONE on the edge that processes the last nibble (counter = 0); on that edge S, Cout and ovf SHALL be updated with the final values.
REQ-018 ovf SHALL equal the carry into bit W-1 XOR the carry out of bit W-1, taken from the last nibble.
REQ-019 done SHALL be 1 for exactly the one cycle the FSM is in DONE; DONE -> IDLE unconditionally on the next edge.
REQ-020 Latency: if start is accepted at edge 0, done SHALL be high between edge WORDS and edge WORDS+1; busy SHALL be high between edge 0 and edge WORDS+1.
REQ-021 start SHALL be ignored in RUN and DONE, with no queuing; a new start is accepted only in IDLE, so back-to-back throughput is one result per WORDS+2 cycles.
REQ-022 Changes to A, B or Cin after the accepting edge SHALL NOT affect the result.
REQ-023 S, Cout and ovf SHALL hold their last completed values in IDLE and RUN.
REQ-024 The intermediate contents of S during RUN are don't-care; consumers SHALL qualify S with done.
REQ-025 With WORDS=1, RUN SHALL last one cycle and the result SHALL equal a single 4-bit ripple-carry add.
REQ-026 The carry SHALL wrap out only via Cout: the sum modulo 2^W goes to S, with no saturation.

Reset
REQ-027 While rst_n=0, the FSM SHALL be in IDLE and busy, done, S, Cout, ovf, the counter, the carry register and the operand registers SHALL all be 0, regardless of clk.
REQ-028 Reset asserted mid-RUN or in DONE SHALL abort the operation with no done pulse; the first start after reset release SHALL be handled normally.
REQ-029 A start coincident with the edge on which rst_n is still 0 SHALL be ignored.

Verification (WORDS=4 unless stated)
REQ-030 A=0xFFFF, B=0x0001, Cin=0 -> S=0x0000, Cout=1, ovf=0; done high exactly in the cycle after edge 4 from acceptance.
REQ-031 A=0x7FFF, B=0x0001, Cin=0 -> S=0x8000, Cout=0, ovf=1; A=0x8000, B=0x8000 -> S=0x0000, Cout=1, ovf=1.
REQ-032 A=0x1234, B=0x4321, Cin=1 -> S=0x5556, Cout=0, ovf=0; A and B randomised after acceptance -> result unchanged.
REQ-033 Second start pulsed during RUN and again in DONE -> ignored, one done pulse only; start in the following IDLE -> accepted.
REQ-034 rst_n dropped at edge 2 of RUN -> all outputs 0 immediately (asynchronously), no done; after release, A=0x0003, B=0x0004 -> S=0x0007.
REQ-035 WORDS=1: A=0xF, B=0x1, Cin=1 -> S=0x1, Cout=1, ovf=0, done one cycle after the edge following acceptance; plus 10k random vectors checked against A+B+Cin.
